// File: rtl/fft4_stream.sv
// Streaming 4-point FFT/IFFT: one frame of 4 complex samples in over 2 beats, 4 bins out over 2 beats.
// Build option FFT4_SCALE_EN: scale every output component by 1/4 (arithmetic shift right by 2).
module fft4_stream #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sop,
  input  logic                     inv,
  input  logic signed [DATA_W-1:0] in0_re,
  input  logic signed [DATA_W-1:0] in0_im,
  input  logic signed [DATA_W-1:0] in1_re,
  input  logic signed [DATA_W-1:0] in1_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sop,
  output logic signed [DATA_W+1:0] out0_re,
  output logic signed [DATA_W+1:0] out0_im,
  output logic signed [DATA_W+1:0] out1_re,
  output logic signed [DATA_W+1:0] out1_im
);

  localparam int unsigned S1_W  = DATA_W + 1;
  localparam int unsigned OUT_W = DATA_W + 2;

  typedef enum logic [2:0] {FILL0, FILL1, BFLY1, BFLY2, OUT0, OUT1} state_t;

  state_t                  state;
  logic                    inv_q;
  logic signed [DATA_W-1:0] x_re [4];
  logic signed [DATA_W-1:0] x_im [4];
  logic signed [S1_W-1:0]   a_re [4];
  logic signed [S1_W-1:0]   a_im [4];
  logic signed [OUT_W-1:0]  y2_re, y2_im, y3_re, y3_im;

  logic signed [S1_W-1:0]  d_re, d_im;
  logic signed [OUT_W-1:0] c0_re, c0_im, c1_re, c1_im, c2_re, c2_im, c3_re, c3_im;

  // Odd-path difference that gets rotated by -j (forward) or +j (inverse)
  assign d_re = S1_W'(x_re[1]) - S1_W'(x_re[3]);
  assign d_im = S1_W'(x_im[1]) - S1_W'(x_im[3]);

  assign c0_re = OUT_W'(a_re[0]) + OUT_W'(a_re[1]);
  assign c0_im = OUT_W'(a_im[0]) + OUT_W'(a_im[1]);
  assign c2_re = OUT_W'(a_re[0]) - OUT_W'(a_re[1]);
  assign c2_im = OUT_W'(a_im[0]) - OUT_W'(a_im[1]);
  assign c1_re = OUT_W'(a_re[2]) + OUT_W'(a_re[3]);
  assign c1_im = OUT_W'(a_im[2]) + OUT_W'(a_im[3]);
  assign c3_re = OUT_W'(a_re[2]) - OUT_W'(a_re[3]);
  assign c3_im = OUT_W'(a_im[2]) - OUT_W'(a_im[3]);

  function automatic logic signed [OUT_W-1:0] scale(input logic signed [OUT_W-1:0] v);
`ifdef FFT4_SCALE_EN
    return v >>> 2;
`else
    return v;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      inv_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_re[i] <= '0;
        x_im[i] <= '0;
        a_re[i] <= '0;
        a_im[i] <= '0;
      end
      y2_re   <= '0;
      y2_im   <= '0;
      y3_re   <= '0;
      y3_im   <= '0;
      out0_re <= '0;
      out0_im <= '0;
      out1_re <= '0;
      out1_im <= '0;
    end else begin
      case (state)
        FILL0: begin
          if (in_valid && in_sop) begin
            x_re[0] <= in0_re;
            x_im[0] <= in0_im;
            x_re[1] <= in1_re;
            x_im[1] <= in1_im;
            inv_q   <= inv;
            state   <= FILL1;
          end
        end
        FILL1: begin
          // A repeated start-of-frame replaces beat 0 rather than completing the frame
          if (in_valid && in_sop) begin
            x_re[0] <= in0_re;
            x_im[0] <= in0_im;
            x_re[1] <= in1_re;
            x_im[1] <= in1_im;
            inv_q   <= inv;
          end else if (in_valid) begin
            x_re[2]  <= in0_re;
            x_im[2]  <= in0_im;
            x_re[3]  <= in1_re;
            x_im[3]  <= in1_im;
            in_ready <= 1'b0;
            state    <= BFLY1;
          end
        end
        BFLY1: begin
          a_re[0] <= S1_W'(x_re[0]) + S1_W'(x_re[2]);
          a_im[0] <= S1_W'(x_im[0]) + S1_W'(x_im[2]);
          a_re[1] <= S1_W'(x_re[1]) + S1_W'(x_re[3]);
          a_im[1] <= S1_W'(x_im[1]) + S1_W'(x_im[3]);
          a_re[2] <= S1_W'(x_re[0]) - S1_W'(x_re[2]);
          a_im[2] <= S1_W'(x_im[0]) - S1_W'(x_im[2]);
          if (inv_q) begin
            a_re[3] <= -d_im;
            a_im[3] <= d_re;
          end else begin
            a_re[3] <= d_im;
            a_im[3] <= -d_re;
          end
          state <= BFLY2;
        end
        BFLY2: begin
          out0_re   <= scale(c0_re);
          out0_im   <= scale(c0_im);
          out1_re   <= scale(c1_re);
          out1_im   <= scale(c1_im);
          y2_re     <= c2_re;
          y2_im     <= c2_im;
          y3_re     <= c3_re;
          y3_im     <= c3_im;
          out_valid <= 1'b1;
          out_sop   <= 1'b1;
          state     <= OUT0;
        end
        OUT0: begin
          if (out_ready) begin
            out0_re <= scale(y2_re);
            out0_im <= scale(y2_im);
            out1_re <= scale(y3_re);
            out1_im <= scale(y3_im);
            out_sop <= 1'b0;
            state   <= OUT1;
          end
        end
        OUT1: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= FILL0;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_sop   <= 1'b0;
          state     <= FILL0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft4_stream.sv
// Randomized bench for fft4_stream against a direct 4-point DFT reference.
module tb_fft4_stream;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OUT_W  = DATA_W + 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_sop;
  logic                     inv;
  logic signed [DATA_W-1:0] in0_re, in0_im, in1_re, in1_im;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_sop;
  logic signed [OUT_W-1:0]  out0_re, out0_im, out1_re, out1_im;

  fft4_stream #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .inv(inv),
    .in0_re(in0_re), .in0_im(in0_im), .in1_re(in1_re), .in1_im(in1_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
    .out0_re(out0_re), .out0_im(out0_im), .out1_re(out1_re), .out1_im(out1_im)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sop;
    int r0, i0, r1, i1;
  } beat_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    fr[4], fi[4];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Capture every output beat that will transfer on the next rising edge
  always @(negedge clk) begin
    beat_t b;
    if (rst_n && out_valid && out_ready) begin
      b.sop = int'(out_sop);
      b.r0  = int'(out0_re);
      b.i0  = int'(out0_im);
      b.r1  = int'(out1_re);
      b.i1  = int'(out1_im);
      got_q.push_back(b);
    end
  end

  // Reference: X[k] = sum_n x[n] * w^(k*n), w = -j (forward) or +j (inverse)
  task automatic model_frame(input bit inv_f);
    int    yr[4], yi[4];
    int    p, tr, ti, t;
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      yr[k] = 0;
      yi[k] = 0;
      for (int n = 0; n < 4; n++) begin
        p  = inv_f ? (k * n) % 4 : (3 * k * n) % 4;
        tr = fr[n];
        ti = fi[n];
        for (int m = 0; m < p; m++) begin
          t  = tr;
          tr = -ti;
          ti = t;
        end
        yr[k] += tr;
        yi[k] += ti;
      end
`ifdef FFT4_SCALE_EN
      yr[k] = yr[k] >>> 2;
      yi[k] = yi[k] >>> 2;
`endif
    end
    b = '{1, yr[0], yi[0], yr[1], yi[1]};
    exp_q.push_back(b);
    b = '{0, yr[2], yi[2], yr[3], yi[3]};
    exp_q.push_back(b);
  endtask

  // Offer one beat; returns #1 after the edge on which it transferred
  task automatic send_beat(input bit sop, input bit inv_b, input int r0, input int i0,
                           input int r1, input int i1, input int gaps);
    logic rdy;
    int   waited;
    in_valid = 1'b0;
    repeat (gaps) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_sop   = sop;
    inv      = inv_b;
    in0_re   = DATA_W'(r0);
    in0_im   = DATA_W'(i0);
    in1_re   = DATA_W'(r1);
    in1_im   = DATA_W'(i1);
    waited   = 0;
    rdy      = 1'b0;
    while (!rdy) begin
      rdy = in_ready;
      @(posedge clk); #1;
      waited++;
      if (!rdy && waited > 100) begin
        check("in_ready_timeout", 0, 1);
        rdy = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic send_frame(input bit inv_f, input bit inv_b1, input int gaps0, input int gaps1);
    send_beat(1'b1, inv_f, fr[0], fi[0], fr[1], fi[1], gaps0);
    send_beat(1'b0, inv_b1, fr[2], fi[2], fr[3], fi[3], gaps1);
  endtask

  task automatic drain(input string tag, input bit rand_bp);
    int    cyc;
    beat_t g, e;
    cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 200) begin
      out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    check({tag, "_beats"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_sop"}, g.sop, e.sop);
      check({tag, "_o0re"}, g.r0, e.r0);
      check({tag, "_o0im"}, g.i0, e.i0);
      check({tag, "_o1re"}, g.r1, e.r1);
      check({tag, "_o1im"}, g.i1, e.i1);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic int rand_sample();
    case ($urandom_range(0, 5))
      0:       return -128;
      1:       return 127;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  initial begin
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    inv       = 1'b0;
    in0_re    = '0;
    in0_im    = '0;
    in1_re    = '0;
    in1_im    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sop", int'(out_sop), 0);
    check("rst_out0_re", int'(out0_re), 0);
    check("rst_out1_im", int'(out1_im), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", int'(in_ready), 1);

    // Forward ramp with latency and throughput checks; beat-1 inv flip must be ignored
    fr = '{0, 1, 2, 3};
    fi = '{0, 0, 0, 0};
    model_frame(1'b0);
    send_frame(1'b0, 1'b1, 0, 0);
    check("lat_e0_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_e1_valid", int'(out_valid), 0);
    check("lat_e1_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    check("lat_e2_valid", int'(out_valid), 1);
    check("lat_e2_sop", int'(out_sop), 1);
    check("lat_e2_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    check("lat_e3_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    check("lat_e4_ready", int'(in_ready), 1);
    drain("ramp_fwd", 1'b0);

    model_frame(1'b1);
    send_frame(1'b1, 1'b0, 0, 0);
    drain("ramp_inv", 1'b0);

    fr = '{-128, -128, -128, -128};
    fi = '{-128, -128, -128, -128};
    model_frame(1'b0);
    send_frame(1'b0, 1'b0, 1, 0);
    drain("extreme", 1'b0);

    // Output held while the consumer stalls in OUT0
    for (int i = 0; i < 4; i++) begin
      fr[i] = rand_sample();
      fi[i] = rand_sample();
    end
    model_frame(1'b0);
    out_ready = 1'b0;
    send_frame(1'b0, 1'b0, 0, 0);
    w = 0;
    while (!out_valid && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", int'(out_valid), 1);
      check("bp_sop", int'(out_sop), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_o0re", int'(out0_re), exp_q[0].r0);
      check("bp_o1im", int'(out1_im), exp_q[0].i1);
      @(posedge clk); #1;
    end
    drain("bp", 1'b0);

    // Stray beat without start-of-frame in FILL0 is dropped
    send_beat(1'b0, 1'b1, 50, -50, 77, 11, 0);
    fr = '{5, -7, 100, -128};
    fi = '{-3, 127, 9, 0};
    model_frame(1'b0);
    send_frame(1'b0, 1'b1, 0, 0);
    drain("drop_nosop", 1'b0);

    // Second start-of-frame replaces the first, including its inv
    send_beat(1'b1, 1'b1, 99, 99, -99, -99, 0);
    fr = '{12, -34, 56, -78};
    fi = '{90, -11, 22, -33};
    model_frame(1'b0);
    send_frame(1'b0, 1'b1, 0, 0);
    drain("double_sop", 1'b0);

    // Reset while the frame is in BFLY2 must leave no output behind
    fr = '{1, 2, 3, 4};
    fi = '{4, 3, 2, 1};
    send_frame(1'b0, 1'b0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_in_ready", int'(in_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_beats", got_q.size(), 0);
    check("mid_rst_in_ready_late", int'(in_ready), 1);
    check("mid_rst_o0re", int'(out0_re), 0);
    got_q.delete();

    // Random frames with idle gaps, beat-1 inv noise and random backpressure
    for (int f = 0; f < 40; f++) begin
      bit inv_f;
      for (int i = 0; i < 4; i++) begin
        fr[i] = rand_sample();
        fi[i] = rand_sample();
      end
      inv_f = 1'($urandom_range(0, 1));
      model_frame(inv_f);
      send_frame(inv_f, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
      drain("rand", 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
